ebi_cbus_bridge: RTL and testbench
==================================

# ebi_cbus_bridge

Bridges the asynchronous external-bus (EBI) strobes from the host CPU onto the internal single-cycle cbus, sequencing each host access into exactly one cbus write or read strobe. Decodes the 12-bit EBI address into a slave select (upper bits) and the 8-bit cbus register address (lower bits), then returns read data to the EBI pins. Sits between the top-level EBI pads and the per-function register blocks (base 12'h000, 12'h100, …), and is the only cbus master in the FPGA.

## Interface
- CBUS_DATA_WIDTH, 16, data width of EBI and cbus
- CBUS_ADDR_WIDTH, 8, cbus register address width
- EBI_ADDR_WIDTH, 12, host address width; bits [11:8] are the slave index
- NUM_SLV, 4, number of cbus slaves; one strobe bit per slave
- RD_LAT, 1, clk cycles from cbus_oe pulse to valid slave rdata (1..7)
- SYNC_STAGES, 2, synchronizer depth for EBI strobes (≥2)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- ebi_cs_n / ebi_we_n / ebi_oe_n  in  1 each  async host strobes, active low
- ebi_addr  in  EBI_ADDR_WIDTH  host address, stable while cs_n low
- ebi_data_in  in  CBUS_DATA_WIDTH  host write data, stable while we_n low
- ebi_data_out  out  CBUS_DATA_WIDTH  read data toward pad
- ebi_data_oe  out  1  pad output enable, high = FPGA drives bus
- cbus_addr  out  CBUS_ADDR_WIDTH  register address to all slaves
- cbus_wdata  out  CBUS_DATA_WIDTH  write data to all slaves
- cbus_we  out  NUM_SLV  one-hot write strobe, one cycle
- cbus_oe  out  NUM_SLV  one-hot read strobe, one cycle
- cbus_rdata_bus  in  NUM_SLV*CBUS_DATA_WIDTH  concatenated slave rdata, slave 0 at LSBs
- busy  out  1  high whenever FSM is not IDLE
- err_cnt  out  8  saturating protocol/decode error count

## Operation
- ebi_cs_n, ebi_we_n, ebi_oe_n each pass through SYNC_STAGES flops; addr/data are not synchronized, captured only once the synced strobe is seen (EBI setup guarantees stability).
- States: IDLE, WR, RD_WAIT, RD_HOLD, RELEASE.
- IDLE: synced cs low & we low & oe high → latch addr/data, go WR. cs low & oe low & we high → latch addr, go RD_WAIT. cs low & we low & oe low → no strobe, err_cnt+1, go RELEASE.
- WR: cbus_we[sel] high exactly this one cycle; → RELEASE.
- RD_WAIT: cbus_oe[sel] high in the first cycle only; counter runs RD_LAT cycles, then capture slave sel rdata into ebi_data_out; → RD_HOLD.
- RD_HOLD: ebi_data_oe high while synced cs & oe low; on either deasserting → ebi_data_oe low, → RELEASE.
- RELEASE: wait for synced cs_n high, → IDLE. One host access yields at most one cbus strobe regardless of strobe duration.
- sel = ebi_addr[11:8]; sel ≥ NUM_SLV: no cbus strobe, write dropped, read returns 16'hDEAD, err_cnt+1.
- err_cnt saturates at 8'hFF; cleared only by rst.
- Reset (any state): all outputs 0, cbus_we/cbus_oe 0, ebi_data_oe 0, FSM IDLE, synchronizers 0 (reads as strobes active; FSM ignores until cs_n seen high once after reset — enters RELEASE out of reset).

## Timing
- Edge E0 = first clk edge sampling a strobe low. cbus_we/cbus_oe high in cycle after edge E0+SYNC_STAGES+1 (cycle 4 with default).
- Read: ebi_data_out valid and ebi_data_oe high RD_LAT+1 cycles after cbus_oe pulse.
- ebi_data_oe drops SYNC_STAGES+1 cycles after oe_n/cs_n rise; host must keep next cycle's turnaround ≥ that.
- Back-to-back accesses: cs_n must be high ≥ SYNC_STAGES+2 clk cycles between accesses.
- cbus_addr/cbus_wdata held from latch until next access latch.

## Structure
- Package cbus_pkg: CBUS_DATA_WIDTH, CBUS_ADDR_WIDTH, EBI_ADDR_WIDTH, slave index constants (SLV_SYS=0, SLV_GTP=1…), ERR_RDATA=16'hDEAD, FSM state encoding.
- Sub-module sync_bit (SYNC_STAGES-deep flop chain, async reset), instantiated for each of the three strobes.

## Test plan
- Write 16'hA5A5 to 12'h005, strobes held 10 cycles → cbus_we = 4'b0001 for one cycle, cbus_addr 8'h05, cbus_wdata 16'hA5A5.
- Read 12'h101, slave 1 rdata 16'h1234 with RD_LAT=1 → cbus_oe = 4'b0010 one cycle, ebi_data_out 16'h1234, ebi_data_oe high until oe_n synced high.
- Read 12'h701 (unmapped) → no cbus_oe, ebi_data_out 16'hDEAD, err_cnt 0→1.
- we_n and oe_n both low under cs_n → no strobes, err_cnt+1; 300 such errors → err_cnt 8'hFF.
- Hold cs_n/we_n low 50 cycles → exactly one cbus_we pulse; second pulse only after cs_n high ≥4 cycles and new access.
- Assert rst during RD_WAIT → all outputs 0 immediately, no pulses until cs_n seen high and a fresh access starts.

Source files
------------

// File: rtl/cbus_pkg.sv
// rtl/cbus_pkg.sv - shared cbus widths, slave map, error data and bridge state encoding
package cbus_pkg;

   localparam int CBUS_DATA_WIDTH = 16;
   localparam int CBUS_ADDR_WIDTH = 8;
   localparam int EBI_ADDR_WIDTH  = 12;
   localparam int SEL_WIDTH       = EBI_ADDR_WIDTH - CBUS_ADDR_WIDTH;

   // Slave index map: slave n owns EBI window 12'hn00..12'hnFF
   localparam int SLV_SYS = 0;
   localparam int SLV_GTP = 1;
   localparam int SLV_FN2 = 2;
   localparam int SLV_FN3 = 3;

   // Returned to the host on reads from an unmapped slave window
   localparam logic [CBUS_DATA_WIDTH-1:0] ERR_RDATA = 16'hDEAD;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR      = 3'd1,
      ST_RD_WAIT = 3'd2,
      ST_RD_HOLD = 3'd3,
      ST_RELEASE = 3'd4
   } cbus_state_e;

   // Upper EBI address bits pick the slave; lower bits go out as cbus_addr
   function automatic logic [SEL_WIDTH-1:0] slave_index(input logic [EBI_ADDR_WIDTH-1:0] addr);
      return addr[EBI_ADDR_WIDTH-1:CBUS_ADDR_WIDTH];
   endfunction

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - multi-flop synchronizer for one asynchronous strobe
module sync_bit #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   // Shift the raw input through STAGES flops; the last one is the synced copy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain <= {STAGES{RST_VAL}};
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/ebi_cbus_bridge.sv
// rtl/ebi_cbus_bridge.sv - sequences async EBI host accesses into single-cycle cbus strobes
module ebi_cbus_bridge
   import cbus_pkg::*;
#(
   parameter int NUM_SLV     = 4,
   parameter int RD_LAT      = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               ebi_cs_n,
   input  logic                               ebi_we_n,
   input  logic                               ebi_oe_n,
   input  logic [EBI_ADDR_WIDTH-1:0]          ebi_addr,
   input  logic [CBUS_DATA_WIDTH-1:0]         ebi_data_in,
   output logic [CBUS_DATA_WIDTH-1:0]         ebi_data_out,
   output logic                               ebi_data_oe,
   output logic [CBUS_ADDR_WIDTH-1:0]         cbus_addr,
   output logic [CBUS_DATA_WIDTH-1:0]         cbus_wdata,
   output logic [NUM_SLV-1:0]                 cbus_we,
   output logic [NUM_SLV-1:0]                 cbus_oe,
   input  logic [NUM_SLV*CBUS_DATA_WIDTH-1:0] cbus_rdata_bus,
   output logic                               busy,
   output logic [7:0]                         err_cnt
);

   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] RD_DONE_CNT = CNT_W'(RD_LAT + 1);

   logic cs_n_s, we_n_s, oe_n_s;

   cbus_state_e state, state_nxt;
   logic        armed;

   logic [SEL_WIDTH-1:0]       sel_in;
   logic                       sel_in_ok;
   logic [SEL_WIDTH-1:0]       sel_q;
   logic                       sel_ok_q;
   logic [CNT_W-1:0]           rd_cnt;
   logic [NUM_SLV-1:0]         sel_onehot;
   logic [CBUS_DATA_WIDTH-1:0] slv_rdata;

   logic wr_req, rd_req, dual_req;
   logic latch_wr, latch_rd, err_inc, rd_done, hold_end;

   // Synchronizers reset to 0, i.e. strobes look active until the host is seen idle
   sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
      .clk (clk), .rst (rst), .d (ebi_cs_n), .q (cs_n_s)
   );
   sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_we (
      .clk (clk), .rst (rst), .d (ebi_we_n), .q (we_n_s)
   );
   sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_oe (
      .clk (clk), .rst (rst), .d (ebi_oe_n), .q (oe_n_s)
   );

   assign sel_in    = slave_index(ebi_addr);
   assign sel_in_ok = ({1'b0, sel_in} < (SEL_WIDTH + 1)'(NUM_SLV));

   assign wr_req   = !cs_n_s && !we_n_s &&  oe_n_s;
   assign rd_req   = !cs_n_s &&  we_n_s && !oe_n_s;
   assign dual_req = !cs_n_s && !we_n_s && !oe_n_s;

   assign busy = (state != ST_IDLE);

   // Decode latched slave index to a one-hot strobe mask and pick its read data
   always_comb begin
      sel_onehot = '0;
      slv_rdata  = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (sel_q == SEL_WIDTH'(i)) begin
            sel_onehot[i] = 1'b1;
            slv_rdata     = cbus_rdata_bus[i*CBUS_DATA_WIDTH +: CBUS_DATA_WIDTH];
         end
      end
   end

   // Next-state and per-cycle control decisions
   always_comb begin
      state_nxt = state;
      latch_wr  = 1'b0;
      latch_rd  = 1'b0;
      err_inc   = 1'b0;
      rd_done   = 1'b0;
      hold_end  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!armed) begin
               state_nxt = ST_RELEASE;
            end else if (dual_req) begin
               err_inc   = 1'b1;
               state_nxt = ST_RELEASE;
            end else if (wr_req) begin
               latch_wr  = 1'b1;
               err_inc   = !sel_in_ok;
               state_nxt = ST_WR;
            end else if (rd_req) begin
               latch_rd  = 1'b1;
               err_inc   = !sel_in_ok;
               state_nxt = ST_RD_WAIT;
            end
         end
         ST_WR: begin
            state_nxt = ST_RELEASE;
         end
         ST_RD_WAIT: begin
            if (rd_cnt == RD_DONE_CNT) begin
               rd_done   = 1'b1;
               state_nxt = ST_RD_HOLD;
            end
         end
         ST_RD_HOLD: begin
            if (cs_n_s || oe_n_s) begin
               hold_end  = 1'b1;
               state_nxt = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (cs_n_s) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Arm only after the host has been seen idle once, so a strobe held across reset is ignored
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         armed <= 1'b0;
      end else if (state == ST_RELEASE) begin
         armed <= 1'b1;
      end
   end

   // Capture address, data and slave select once the synced strobe is seen
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cbus_addr  <= '0;
         cbus_wdata <= '0;
         sel_q      <= '0;
         sel_ok_q   <= 1'b0;
      end else if (latch_wr || latch_rd) begin
         cbus_addr <= ebi_addr[CBUS_ADDR_WIDTH-1:0];
         sel_q     <= sel_in;
         sel_ok_q  <= sel_in_ok;
         if (latch_wr) begin
            cbus_wdata <= ebi_data_in;
         end
      end
   end

   // Read latency counter, zeroed at read latch and counting through RD_WAIT
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_cnt <= '0;
      end else if (latch_rd) begin
         rd_cnt <= '0;
      end else if (state == ST_RD_WAIT) begin
         rd_cnt <= rd_cnt + 1'b1;
      end
   end

   // Registered one-cycle strobes; unmapped selects produce no strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cbus_we <= '0;
         cbus_oe <= '0;
      end else begin
         cbus_we <= (state == ST_WR && sel_ok_q) ? sel_onehot : '0;
         cbus_oe <= (state == ST_RD_WAIT && rd_cnt == '0 && sel_ok_q) ? sel_onehot : '0;
      end
   end

   // Return read data to the pads and drive them until the host ends the read
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ebi_data_out <= '0;
         ebi_data_oe  <= 1'b0;
      end else if (rd_done) begin
         ebi_data_out <= sel_ok_q ? slv_rdata : ERR_RDATA;
         ebi_data_oe  <= 1'b1;
      end else if (hold_end) begin
         ebi_data_oe  <= 1'b0;
      end
   end

   // Saturating protocol/decode error counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (err_inc && err_cnt != 8'hFF) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_ebi_cbus_bridge.sv
// tb/tb_ebi_cbus_bridge.sv - scoreboard bench for ebi_cbus_bridge with random host accesses
module tb_ebi_cbus_bridge;

   localparam int SS      = 2;
   localparam int RD_LAT  = 1;
   localparam int NUM_SLV = 4;
   localparam int DW      = 16;

   localparam int K_WR   = 0;
   localparam int K_RD   = 1;
   localparam int K_DUAL = 2;

   localparam int EV_WE = 0;
   localparam int EV_OE = 1;
   localparam int EV_RD = 2;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic                    ebi_cs_n = 1'b1;
   logic                    ebi_we_n = 1'b1;
   logic                    ebi_oe_n = 1'b1;
   logic [11:0]             ebi_addr = '0;
   logic [DW-1:0]           ebi_data_in = '0;
   logic [DW-1:0]           ebi_data_out;
   logic                    ebi_data_oe;
   logic [7:0]              cbus_addr;
   logic [DW-1:0]           cbus_wdata;
   logic [NUM_SLV-1:0]      cbus_we;
   logic [NUM_SLV-1:0]      cbus_oe;
   logic [NUM_SLV*DW-1:0]   cbus_rdata_bus = '0;
   logic                    busy;
   logic [7:0]              err_cnt;

   typedef struct {
      int          kind;
      logic [3:0]  strb;
      logic [7:0]  addr;
      logic [15:0] data;
      int          cyc;
   } ev_t;

   ev_t         exp_q[$];
   logic [15:0] slv_val [NUM_SLV];
   int          model_err = 0;
   int          cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;
   logic        oe_prev = 1'b0;

   ebi_cbus_bridge #(
      .NUM_SLV     (NUM_SLV),
      .RD_LAT      (RD_LAT),
      .SYNC_STAGES (SS)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .ebi_cs_n       (ebi_cs_n),
      .ebi_we_n       (ebi_we_n),
      .ebi_oe_n       (ebi_oe_n),
      .ebi_addr       (ebi_addr),
      .ebi_data_in    (ebi_data_in),
      .ebi_data_out   (ebi_data_out),
      .ebi_data_oe    (ebi_data_oe),
      .cbus_addr      (cbus_addr),
      .cbus_wdata     (cbus_wdata),
      .cbus_we        (cbus_we),
      .cbus_oe        (cbus_oe),
      .cbus_rdata_bus (cbus_rdata_bus),
      .busy           (busy),
      .err_cnt        (err_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Slave model: data valid for exactly one cycle, RD_LAT=1 after its read strobe
   always @(posedge clk) begin
      for (int i = 0; i < NUM_SLV; i++) begin
         cbus_rdata_bus[i*DW +: DW] <= cbus_oe[i] ? slv_val[i] : 16'($urandom);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic pop_check(input int kind);
      ev_t e;
      bit  ok;
      n_chk++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL unexpected_event kind %0d at cycle %0d: we=%b oe=%b data_oe=%b",
                  kind, cyc, cbus_we, cbus_oe, ebi_data_oe);
         return;
      end
      e = exp_q.pop_front();
      case (kind)
         EV_WE:   ok = (e.kind == EV_WE) && (cbus_we == e.strb) && (cbus_addr == e.addr) &&
                       (cbus_wdata == e.data) && (cyc == e.cyc);
         EV_OE:   ok = (e.kind == EV_OE) && (cbus_oe == e.strb) && (cbus_addr == e.addr) &&
                       (cyc == e.cyc);
         default: ok = (e.kind == EV_RD) && (ebi_data_out == e.data) && (cyc == e.cyc);
      endcase
      if (!ok) begin
         n_fail++;
         $display("FAIL event kind %0d: got kind %0d we=%b oe=%b addr=%0h wdata=%0h rdata=%0h cyc=%0d; expected kind %0d strb=%b addr=%0h data=%0h cyc=%0d",
                  kind, kind, cbus_we, cbus_oe, cbus_addr, cbus_wdata, ebi_data_out, cyc,
                  e.kind, e.strb, e.addr, e.data, e.cyc);
      end
   endtask

   // Monitor: every observed strobe or read-data presentation must match the next expectation
   always @(negedge clk) begin
      if (cbus_we !== '0) pop_check(EV_WE);
      if (cbus_oe !== '0) pop_check(EV_OE);
      if (ebi_data_oe === 1'b1 && oe_prev === 1'b0) pop_check(EV_RD);
      oe_prev = ebi_data_oe;
   end

   function automatic void bump_err();
      if (model_err < 255) model_err++;
   endfunction

   // One host access starting at a negedge; expectations derived from the address map
   task automatic do_access(input int kind, input logic [11:0] addr, input logic [15:0] wdata,
                            input logic [15:0] rval, input int hold, input int gap);
      int   k;
      int   sel;
      bit   mapped;
      ev_t  e;
      k      = cyc;
      sel    = int'(addr[11:8]);
      mapped = (sel < NUM_SLV);
      if (kind == K_WR) begin
         if (mapped) begin
            e = '{kind: EV_WE, strb: 4'(1 << sel), addr: addr[7:0], data: wdata, cyc: k + SS + 2};
            exp_q.push_back(e);
         end else begin
            bump_err();
         end
      end else if (kind == K_RD) begin
         if (mapped) begin
            slv_val[sel] = rval;
            e = '{kind: EV_OE, strb: 4'(1 << sel), addr: addr[7:0], data: 16'h0, cyc: k + SS + 2};
            exp_q.push_back(e);
         end else begin
            bump_err();
         end
         e = '{kind: EV_RD, strb: 4'h0, addr: 8'h0, data: mapped ? rval : 16'hDEAD,
               cyc: k + SS + 2 + RD_LAT + 1};
         exp_q.push_back(e);
      end else begin
         bump_err();
      end
      ebi_addr    = addr;
      ebi_data_in = wdata;
      ebi_cs_n    = 1'b0;
      ebi_we_n    = (kind == K_RD);
      ebi_oe_n    = (kind == K_WR);
      repeat (hold) @(negedge clk);
      ebi_cs_n    = 1'b1;
      ebi_we_n    = 1'b1;
      ebi_oe_n    = 1'b1;
      ebi_addr    = 12'($urandom);
      ebi_data_in = 16'($urandom);
      for (int i = 1; i <= gap; i++) begin
         @(negedge clk);
         if (kind == K_RD && i == SS)     check("data_oe_still_driven", 32'(ebi_data_oe), 32'd1);
         if (kind == K_RD && i == SS + 1) check("data_oe_released", 32'(ebi_data_oe), 32'd0);
      end
      check("busy_idle", 32'(busy), 32'd0);
      check("err_cnt", 32'(err_cnt), 32'(model_err));
   endtask

   initial begin
      for (int i = 0; i < NUM_SLV; i++) slv_val[i] = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_cbus_we", 32'(cbus_we), 32'd0);
      check("rst_cbus_oe", 32'(cbus_oe), 32'd0);
      check("rst_data_oe", 32'(ebi_data_oe), 32'd0);
      check("rst_data_out", 32'(ebi_data_out), 32'd0);
      check("rst_cbus_addr", 32'(cbus_addr), 32'd0);
      check("rst_cbus_wdata", 32'(cbus_wdata), 32'd0);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      repeat (8) @(negedge clk);

      // Directed accesses
      do_access(K_WR, 12'h005, 16'hA5A5, 16'h0, 10, SS + 2);
      do_access(K_RD, 12'h101, 16'h0, 16'h1234, 8, SS + 2);
      do_access(K_RD, 12'h701, 16'h0, 16'h0, 8, SS + 2);
      check("unmapped_err_one", 32'(err_cnt), 32'd1);
      do_access(K_WR, 12'h0A3, 16'h5A5A, 16'h0, 50, SS + 2);
      do_access(K_WR, 12'h2F0, 16'hC3C3, 16'h0, 4, SS + 2);

      // Random mix of writes, reads and illegal dual strobes over mapped and unmapped slaves
      for (int n = 0; n < 150; n++) begin
         int          kind;
         int          hold;
         logic [11:0] a;
         kind = ($urandom_range(0, 9) < 1) ? K_DUAL : int'($urandom_range(0, 1));
         a    = {4'($urandom_range(0, 5)), 8'($urandom)};
         hold = (kind == K_RD) ? 7 + int'($urandom_range(0, 5)) : 4 + int'($urandom_range(0, 8));
         do_access(kind, a, 16'($urandom), 16'($urandom), hold, SS + 2 + int'($urandom_range(0, 3)));
      end

      // Reset during RD_WAIT while the host keeps its strobes asserted
      ebi_addr = 12'h102;
      ebi_cs_n = 1'b0;
      ebi_oe_n = 1'b0;
      slv_val[1] = 16'hBEEF;
      repeat (SS + 1) @(negedge clk);
      rst = 1'b1;
      #1;
      model_err = 0;
      check("rd_rst_cbus_oe", 32'(cbus_oe), 32'd0);
      check("rd_rst_cbus_addr", 32'(cbus_addr), 32'd0);
      check("rd_rst_data_oe", 32'(ebi_data_oe), 32'd0);
      check("rd_rst_busy", 32'(busy), 32'd0);
      check("rd_rst_err_cnt", 32'(err_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("held_strobe_no_read_data", 32'(ebi_data_oe), 32'd0);
      ebi_cs_n = 1'b1;
      ebi_oe_n = 1'b1;
      repeat (SS + 4) @(negedge clk);
      do_access(K_WR, 12'h3C7, 16'h0F0F, 16'h0, 6, SS + 2);
      do_access(K_RD, 12'h0FE, 16'h0, 16'h7E57, 9, SS + 2);

      // Error counter saturation
      for (int n = 0; n < 300; n++) begin
         do_access(K_DUAL, 12'($urandom), 16'($urandom), 16'h0, 4, SS + 2);
      end
      check("err_cnt_saturated", 32'(err_cnt), 32'hFF);

      repeat (10) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Global bound on run length
   initial begin
      #2000000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

endmodule
